nco_quad_mixer_rx: RTL and testbench
====================================

Name: nco_quad_mixer_rx

Overview:
Receive-side consumer of the NCO sin/cos stream. It buffers incoming ADC samples in a small FIFO and pairs each buffered sample with the next valid NCO sample. It then multiplies to produce a downconverted complex baseband pair, I = x·cos and Q = −x·sin, with rounding and saturation. It sits between the ADC capture path and the CIC/decimation chain, absorbing the latency mismatch between ADC arrival and NCO out_valid.

Parameters:
ADW, 16, ADC sample width, signed Q1.(ADW-1)
MPR, 16, NCO sin/cos width, signed Q1.(MPR-1)
OW, 16, output I/Q width, signed Q1.(OW-1); OW <= ADW+MPR-1
FD, 8, ADC FIFO depth in words, power of two
FAW, 3, log2(FD)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
clken  in  1  global clock enable; low freezes all state
adc_data  in  ADW  signed ADC sample
adc_valid  in  1  adc_data valid this cycle
fsin_i  in  MPR  NCO sine sample
fcos_i  in  MPR  NCO cosine sample
nco_valid  in  1  NCO out_valid
i_out  out  OW  in-phase result
q_out  out  OW  quadrature result
out_valid  out  1  i_out/q_out valid, one-cycle pulse per pair
fifo_level  out  FAW+1  current FIFO occupancy, 0..FD
fifo_overflow  out  1  sticky: ADC sample dropped on full FIFO
nco_miss_cnt  out  16  saturating count of NCO samples discarded because FIFO was empty

Behaviour:
- Reset (synchronous, active-high): clears FIFO pointers and level, all pipeline registers, i_out=0, q_out=0, out_valid=0, fifo_overflow=0, nco_miss_cnt=0. A reset mid-operation discards any in-flight pairs; no out_valid is produced for them.
- All state advances only when clken=1. With clken=0, every register, including out_valid, holds its value.
- Push: clken & adc_valid & (not full, or pop this cycle). The sample is written at the write pointer. The pointer wraps modulo FD.
- Push while full with no pop: the sample is dropped and fifo_overflow is set to 1 until reset.
- Pop/pair: clken & nco_valid & level>0. The head sample and fsin_i/fcos_i are registered into stage 1. The read pointer wraps modulo FD.
- nco_valid while level=0: the NCO sample is discarded and nco_miss_cnt increments, saturating at 65535. There is no same-cycle bypass: a push in the same cycle as an empty-FIFO nco_valid does not pair.
- Simultaneous push and pop: both take effect and level is unchanged, including when full and when level=1.
- Stage 1: register x, cos, and nsin = −sin. Negation saturates: −(−2^(MPR-1)) → 2^(MPR-1)−1.
- Stage 2: signed products pI = x·cos and pQ = x·nsin, each ADW+MPR bits.
- Stage 3, rounding and saturation: with SH = ADW+MPR−1−OW, r = (p + 2^(SH−1)) >>> SH (round half up). Saturate r to [−2^(OW−1), 2^(OW−1)−1]. Register the results to i_out/q_out.
- Latency: out_valid asserts exactly 3 enabled cycles after the pop cycle. i_out/q_out hold their values between pulses.
- fifo_level is registered and reflects push/pop from the previous enabled cycle.

Test Plan:
- Basic: reset, push x=16384, then nco_valid with cos=32767, sin=0 → 3 cycles later out_valid=1, i_out=16384, q_out=0; fifo_level returns to 0.
- Saturation: x=−32768, cos=−32768, sin=−32768 → i_out=32767; nsin saturates to 32767, so q_out=round(−32768·32767/32768)=−32767.
- Overflow: push 9 samples with no nco_valid → fifo_level=8, fifo_overflow=1. Then 8 nco_valid pops → 8 outputs in push order for samples 1..8; the 9th sample is absent.
- Empty miss: assert nco_valid 3 times with the FIFO empty → no out_valid, nco_miss_cnt=3. A push and nco_valid in the same cycle on an empty FIFO → no pairing, nco_miss_cnt=4, fifo_level=1.
- Full simultaneous: with FIFO full, push and pop in the same cycle → fifo_level stays 8, fifo_overflow stays 0; pointer wrap preserves sample order over 20 continuous push/pop cycles.
- clken/reset: deassert clken for 5 cycles mid-pipeline → outputs frozen, and the pair emerges after 3 enabled cycles. Assert reset with 2 pairs in flight → out_valid stays 0 and all outputs and counters read 0.

Source files
------------

// File: rtl/nco_quad_mixer_rx.sv
// nco_quad_mixer_rx: buffers ADC samples in a FIFO, pairs each with the next
// valid NCO sin/cos sample and mixes to baseband: I = x*cos, Q = -x*sin.
// Ports: clk, reset (sync, active-high), clken (global enable),
//   adc_data/adc_valid (ADC input), fsin_i/fcos_i/nco_valid (NCO input),
//   i_out/q_out/out_valid (rounded, saturated baseband pair),
//   fifo_level, fifo_overflow (sticky), nco_miss_cnt (saturating).
module nco_quad_mixer_rx #(
    parameter int ADW = 16,
    parameter int MPR = 16,
    parameter int OW  = 16,
    parameter int FD  = 8,
    parameter int FAW = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clken,
    input  logic [ADW-1:0] adc_data,
    input  logic           adc_valid,
    input  logic [MPR-1:0] fsin_i,
    input  logic [MPR-1:0] fcos_i,
    input  logic           nco_valid,
    output logic [OW-1:0]  i_out,
    output logic [OW-1:0]  q_out,
    output logic           out_valid,
    output logic [FAW:0]   fifo_level,
    output logic           fifo_overflow,
    output logic [15:0]    nco_miss_cnt
);

    localparam int PW = ADW + MPR;
    localparam int SH = PW - 1 - OW;
    localparam logic signed [PW:0] RND =
        (SH > 0) ? ((PW+1)'(1) << (SH - 1)) : '0;
    localparam logic [MPR-1:0] SIN_MIN = {1'b1, {(MPR-1){1'b0}}};
    localparam logic [MPR-1:0] SIN_MAX = {1'b0, {(MPR-1){1'b1}}};

    // Round half up, then clamp to the OW-bit signed range. The shifted
    // value fits when all bits from the OW-1 position upward agree.
    function automatic logic [OW-1:0] rnd_sat(input logic signed [PW-1:0] p);
        logic signed [PW:0] r;
        r = ((PW+1)'(p) + RND) >>> SH;
        if (r[PW:OW-1] == '0 || r[PW:OW-1] == '1)
            return r[OW-1:0];
        return r[PW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    endfunction

    logic [ADW-1:0] mem [FD];
    logic [FAW-1:0] wr_ptr, rd_ptr;
    logic           full, empty, push, pop, miss;

    assign full  = (fifo_level == (FAW+1)'(FD));
    assign empty = (fifo_level == '0);
    assign pop   = clken & nco_valid & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push  = clken & adc_valid & (~full | pop);
    assign miss  = clken & nco_valid & empty;

    logic [MPR-1:0] nsin;
    assign nsin = (fsin_i == SIN_MIN) ? SIN_MAX : -fsin_i;

    logic                  s1_valid, s2_valid;
    logic signed [ADW-1:0] s1_x;
    logic signed [MPR-1:0] s1_cos, s1_nsin;
    logic signed [PW-1:0]  s2_pi, s2_pq;
    logic signed [PW-1:0]  x_ext, c_ext, ns_ext;

    assign x_ext  = PW'(s1_x);
    assign c_ext  = PW'(s1_cos);
    assign ns_ext = PW'(s1_nsin);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= adc_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            fifo_overflow <= 1'b0;
            nco_miss_cnt  <= '0;
            s1_valid      <= 1'b0;
            s1_x          <= '0;
            s1_cos        <= '0;
            s1_nsin       <= '0;
            s2_valid      <= 1'b0;
            s2_pi         <= '0;
            s2_pq         <= '0;
            out_valid     <= 1'b0;
            i_out         <= '0;
            q_out         <= '0;
        end else if (clken) begin
            if (push)
                wr_ptr <= wr_ptr + FAW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FAW'(1);
            if (push && !pop)
                fifo_level <= fifo_level + (FAW+1)'(1);
            else if (pop && !push)
                fifo_level <= fifo_level - (FAW+1)'(1);
            if (adc_valid && full && !pop)
                fifo_overflow <= 1'b1;
            if (miss && nco_miss_cnt != 16'hFFFF)
                nco_miss_cnt <= nco_miss_cnt + 16'd1;

            s1_valid <= pop;
            if (pop) begin
                s1_x    <= mem[rd_ptr];
                s1_cos  <= fcos_i;
                s1_nsin <= nsin;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_pi <= x_ext * c_ext;
                s2_pq <= x_ext * ns_ext;
            end

            out_valid <= s2_valid;
            if (s2_valid) begin
                i_out <= rnd_sat(s2_pi);
                q_out <= rnd_sat(s2_pq);
            end
        end
    end

endmodule

// File: tb/tb_nco_quad_mixer_rx.sv
// tb_nco_quad_mixer_rx: directed tests for nco_quad_mixer_rx.
// Ports: none (drives clk/reset/clken and ADC/NCO streams into the DUT).
module tb_nco_quad_mixer_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clken = 1'b1;
    logic [15:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic [15:0] fsin_i = '0;
    logic [15:0] fcos_i = '0;
    logic        nco_valid = 1'b0;
    logic [15:0] i_out, q_out;
    logic        out_valid;
    logic [3:0]  fifo_level;
    logic        fifo_overflow;
    logic [15:0] nco_miss_cnt;

    int errors = 0;
    int checks = 0;
    logic [31:0] outq[$];

    nco_quad_mixer_rx dut (
        .clk(clk), .reset(reset), .clken(clken),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .fsin_i(fsin_i), .fcos_i(fcos_i), .nco_valid(nco_valid),
        .i_out(i_out), .q_out(q_out), .out_valid(out_valid),
        .fifo_level(fifo_level), .fifo_overflow(fifo_overflow),
        .nco_miss_cnt(nco_miss_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (clken && out_valid)
            outq.push_back({i_out, q_out});

    function automatic logic [31:0] mix(input int x, input int s, input int c);
        longint ns, pi, pq, ri, rq;
        ns = (s == -32768) ? 32767 : -s;
        pi = longint'(x) * longint'(c);
        pq = longint'(x) * ns;
        ri = (pi + 16384) >>> 15;
        rq = (pq + 16384) >>> 15;
        if (ri > 32767) ri = 32767;
        if (ri < -32768) ri = -32768;
        if (rq > 32767) rq = 32767;
        if (rq < -32768) rq = -32768;
        return {16'(ri), 16'(rq)};
    endfunction

    task automatic cyc(input logic av, input int x,
                       input logic nv, input int s, input int c);
        adc_valid = av;
        adc_data  = 16'(x);
        nco_valid = nv;
        fsin_i    = 16'(s);
        fcos_i    = 16'(c);
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
        nco_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        outq.delete();
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || i_out !== 16'd0 || q_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_out: ov=%b i=%h q=%h want 0", out_valid, i_out, q_out);
        end
        checks++;
        if (fifo_level !== 4'd0 || fifo_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_fifo: lvl=%0d ovf=%b want 0", fifo_level, fifo_overflow);
        end
        checks++;
        if (nco_miss_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_miss: got %0d want 0", nco_miss_cnt);
        end
    endtask

    task automatic test_basic;
        do_reset();
        cyc(1, 16384, 0, 0, 0);
        checks++;
        if (fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL basic_lvl1: got %0d want 1", fifo_level);
        end
        cyc(0, 0, 1, 0, 32767);
        checks++;
        if (fifo_level !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop: lvl=%0d ov=%b want 0/0", fifo_level, out_valid);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: ov=%b want 0", out_valid);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b1 || i_out !== 16'd16384 || q_out !== 16'd0) begin
            errors++;
            $display("FAIL basic_out: ov=%b i=%0d q=%0d want 1/16384/0",
                     out_valid, $signed(i_out), $signed(q_out));
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0 || i_out !== 16'd16384) begin
            errors++;
            $display("FAIL basic_hold: ov=%b i=%0d want 0/16384",
                     out_valid, $signed(i_out));
        end
    endtask

    task automatic test_saturation;
        do_reset();
        cyc(1, -32768, 0, 0, 0);
        cyc(0, 0, 1, -32768, -32768);
        idle(2);
        checks++;
        if (out_valid !== 1'b1 || $signed(i_out) !== 16'sd32767 ||
            $signed(q_out) !== -16'sd32767) begin
            errors++;
            $display("FAIL sat: ov=%b i=%0d q=%0d want 1/32767/-32767",
                     out_valid, $signed(i_out), $signed(q_out));
        end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int k = 1; k <= 9; k++) cyc(1, 1000 * k, 0, 0, 0);
        checks++;
        if (fifo_level !== 4'd8 || fifo_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state: lvl=%0d ovf=%b want 8/1", fifo_level, fifo_overflow);
        end
        for (int k = 0; k < 8; k++) cyc(0, 0, 1, -16384, 16384);
        idle(4);
        checks++;
        if (outq.size() != 8 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL ovf_count: outs=%0d lvl=%0d want 8/0", outq.size(), fifo_level);
        end
        for (int k = 0; k < outq.size(); k++) begin
            checks++;
            if (outq[k] !== mix(1000 * (k + 1), -16384, 16384)) begin
                errors++;
                $display("FAIL ovf_data[%0d]: got %h want %h", k, outq[k],
                         mix(1000 * (k + 1), -16384, 16384));
            end
        end
    endtask

    task automatic test_empty_miss;
        do_reset();
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 100, 200);
        idle(4);
        checks++;
        if (nco_miss_cnt !== 16'd3 || outq.size() != 0) begin
            errors++;
            $display("FAIL miss3: cnt=%0d outs=%0d want 3/0", nco_miss_cnt, outq.size());
        end
        cyc(1, 7777, 1, 100, 200);
        checks++;
        if (nco_miss_cnt !== 16'd4 || fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL miss_same: cnt=%0d lvl=%0d want 4/1", nco_miss_cnt, fifo_level);
        end
        idle(4);
        checks++;
        if (outq.size() != 0) begin
            errors++;
            $display("FAIL miss_nopair: outs=%0d want 0", outq.size());
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        do_reset();
        for (int k = 1; k <= 8; k++) cyc(1, 100 * k, 0, 0, 0);
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            cyc(1, 100 * (9 + j), 1, 12345, 20000);
            if (fifo_level !== 4'd8) bad++;
        end
        checks++;
        if (bad != 0 || fifo_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_simul: bad_lvl=%0d ovf=%b want 0/0", bad, fifo_overflow);
        end
        for (int k = 0; k < 8; k++) cyc(0, 0, 1, 12345, 20000);
        idle(4);
        checks++;
        if (outq.size() != 28) begin
            errors++;
            $display("FAIL b2b_count: outs=%0d want 28", outq.size());
        end
        bad = 0;
        for (int k = 0; k < outq.size(); k++)
            if (outq[k] !== mix(100 * (k + 1), 12345, 20000)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_order: %0d wrong of %0d want 0", bad, outq.size());
        end
    endtask

    task automatic test_clken;
        logic [31:0] e;
        e = mix(5000, 16384, 32767);
        do_reset();
        cyc(1, 5000, 0, 0, 0);
        cyc(0, 0, 1, 16384, 32767);
        idle(1);
        clken = 1'b0;
        for (int k = 0; k < 5; k++) cyc(1, 9, 1, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0 || nco_miss_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clken_frozen: ov=%b lvl=%0d miss=%0d want 0/0/0",
                     out_valid, fifo_level, nco_miss_cnt);
        end
        clken = 1'b1;
        idle(1);
        checks++;
        if (out_valid !== 1'b1 || {i_out, q_out} !== e) begin
            errors++;
            $display("FAIL clken_out: ov=%b iq=%h want 1/%h", out_valid, {i_out, q_out}, e);
        end
        clken = 1'b0;
        idle(2);
        checks++;
        if (out_valid !== 1'b1 || {i_out, q_out} !== e) begin
            errors++;
            $display("FAIL clken_hold: ov=%b iq=%h want 1/%h", out_valid, {i_out, q_out}, e);
        end
        clken = 1'b1;
        idle(1);
        checks++;
        if (out_valid !== 1'b0 || outq.size() != 1) begin
            errors++;
            $display("FAIL clken_pulse: ov=%b outs=%0d want 0/1", out_valid, outq.size());
        end
    endtask

    task automatic test_reset_inflight;
        int seen;
        do_reset();
        cyc(0, 0, 1, 0, 0);
        cyc(1, 3000, 0, 0, 0);
        cyc(1, 4000, 0, 0, 0);
        cyc(0, 0, 1, 0, 32767);
        cyc(0, 0, 1, 0, 32767);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || outq.size() != 0) begin
            errors++;
            $display("FAIL rst_flight_ov: pulses=%0d outs=%0d want 0/0", seen, outq.size());
        end
        checks++;
        if (i_out !== 16'd0 || q_out !== 16'd0 || fifo_level !== 4'd0 ||
            nco_miss_cnt !== 16'd0 || fifo_overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_flight_state: i=%h q=%h lvl=%0d miss=%0d ovf=%b want 0",
                     i_out, q_out, fifo_level, nco_miss_cnt, fifo_overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_overflow();
        test_empty_miss();
        test_back_to_back();
        test_clken();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
